// File: rtl/gauss_frame_loader.sv
// Serial-to-frame loader for the Gaussian filter: packs a row-major pixel stream
// into a flat frame bus, launches the filter with a start pulse and holds the frame until done.
//
// state  | meaning
// FILL   | accepting pixels, pix_ready high
// LAUNCH | one cycle: start pulse, frame counted
// WAIT   | frame frozen on image_out until filt_done
module gauss_frame_loader #(
  parameter int rows       = 4,
  parameter int cols       = 4,
  parameter int data_width = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [data_width-1:0]            pix_in,
  input  logic                             pix_valid,
  input  logic                             pix_last,
  output logic                             pix_ready,
  output logic [data_width*rows*cols-1:0]  image_out,
  output logic                             image_ready,
  output logic                             start,
  input  logic                             filt_done,
  output logic                             frame_err,
  output logic [7:0]                       frame_cnt
);

  localparam int N     = rows * cols;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [data_width-1:0]  pix_q [N];
  logic                   frame_err_q, frame_err_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;

  logic beat_acc;
  logic at_last_idx;
  logic frame_ok;
  logic frame_bad;

  assign beat_acc    = pix_valid && pix_ready;
  assign at_last_idx = (idx_q == LAST_IDX);
  // A frame closes on the last index or on pix_last; only both together is well formed.
  assign frame_ok    = beat_acc && at_last_idx && pix_last;
  assign frame_bad   = beat_acc && (at_last_idx ^ pix_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (frame_ok)  state_d = LAUNCH;
      LAUNCH:                 state_d = WAIT;
      WAIT:    if (filt_done) state_d = FILL;
      default:                state_d = FILL;
    endcase
  end

  always_comb begin
    pix_ready   = 1'b0;
    start       = 1'b0;
    image_ready = 1'b0;
    unique case (state_q)
      FILL:    pix_ready = 1'b1;
      LAUNCH: begin
        start       = 1'b1;
        image_ready = 1'b1;
      end
      WAIT:    image_ready = 1'b1;
      default: pix_ready = 1'b0;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    frame_err_d = frame_bad;
    frame_cnt_d = frame_cnt_q;
    if (beat_acc) begin
      if (at_last_idx || pix_last) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (state_q == LAUNCH) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 8'd0;
      for (int i = 0; i < N; i++) begin
        pix_q[i] <= '0;
      end
    end else begin
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
      // Bytes of a discarded partial frame stay in place; the next frame overwrites them.
      if (beat_acc) begin
        pix_q[idx_q] <= pix_in;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign image_out[g*data_width +: data_width] = pix_q[g];
  end

  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_gauss_frame_loader.sv
// Bench for gauss_frame_loader: scenario table, hand sequences for timing/reset corners,
// and a randomized run against a per-cycle reference model of the frame rules.
module tb_gauss_frame_loader;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int N    = ROWS * COLS;

  logic              clk;
  logic              rst;
  logic [DW-1:0]     pix_in;
  logic              pix_valid;
  logic              pix_last;
  logic              pix_ready;
  logic [DW*N-1:0]   image_out;
  logic              image_ready;
  logic              start;
  logic              filt_done;
  logic              frame_err;
  logic [7:0]        frame_cnt;

  int vec;
  int miscompares;
  int exp_frames;

  gauss_frame_loader #(.rows(ROWS), .cols(COLS), .data_width(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .image_out  (image_out),
    .image_ready(image_ready),
    .start      (start),
    .filt_done  (filt_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the frame is a growing list of pixels; busy covers launch + wait.
  bit          m_launch;
  bit          m_wait;
  bit          m_err;
  int          m_len;
  logic [7:0]  m_img [N];
  logic [7:0]  m_cnt;

  function automatic void model_step();
    if (!rst) begin
      m_launch = 0; m_wait = 0; m_err = 0; m_len = 0; m_cnt = 8'd0;
      foreach (m_img[i]) m_img[i] = 8'h00;
      return;
    end
    m_err = 0;
    if (m_launch) begin
      m_launch = 0;
      m_wait   = 1;
      m_cnt    = m_cnt + 8'd1;
    end else if (m_wait) begin
      if (filt_done) m_wait = 0;
    end else if (pix_valid) begin
      m_img[m_len] = pix_in;
      if (m_len == N - 1 || pix_last) begin
        if (m_len == N - 1 && pix_last) m_launch = 1;
        else m_err = 1;
        m_len = 0;
      end else begin
        m_len = m_len + 1;
      end
    end
  endfunction

  function automatic logic [DW*N-1:0] model_image();
    logic [DW*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = m_img[i];
    return v;
  endfunction

  task automatic model_compare();
    logic busy;
    busy = m_launch | m_wait;
    vec++;
    if (pix_ready !== !busy || start !== m_launch || image_ready !== busy ||
        frame_err !== m_err || frame_cnt !== m_cnt || image_out !== model_image()) begin
      miscompares++;
      $display("FAIL model t=%0t rdy=%b/%b start=%b/%b irdy=%b/%b err=%b/%b cnt=%0d/%0d img=%h/%h",
               $time, pix_ready, !busy, start, m_launch, image_ready, busy,
               frame_err, m_err, frame_cnt, m_cnt, image_out, model_image());
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_compare();
  endtask

  task automatic chk(input string name, input logic [DW*N-1:0] act, input logic [DW*N-1:0] exp);
    vec++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [7:0] p, input logic l);
    int k;
    k = 0;
    pix_in = p; pix_last = l; pix_valid = 1'b1;
    while (!pix_ready && k < 40) begin
      tick();
      k++;
    end
    if (k == 40) begin
      vec++;
      miscompares++;
      $display("FAIL ready_timeout got pix_ready=0 expected 1");
    end
    tick();
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  task automatic release_filter(input int delay);
    repeat (delay) tick();
    filt_done = 1'b1;
    tick();
    filt_done = 1'b0;
  endtask

  typedef struct {
    string name;
    int    n;
    int    last_at;
    bit    gap;
    bit    exp_start;
    bit    exp_err;
  } scen_t;

  scen_t scen [5];

  initial begin
    logic [DW*N-1:0] exp_img;
    logic [DW*N-1:0] held;
    logic [7:0] base;

    vec = 0; miscompares = 0; exp_frames = 0;
    rst = 1'b0; pix_in = '0; pix_valid = 1'b0; pix_last = 1'b0; filt_done = 1'b0;

    scen[0] = '{"gapped",        16, 15, 1'b1, 1'b1, 1'b0};
    scen[1] = '{"early_last",     5,  4, 1'b0, 1'b0, 1'b1};
    scen[2] = '{"after_early",   16, 15, 1'b0, 1'b1, 1'b0};
    scen[3] = '{"missing_last",  16, -1, 1'b0, 1'b0, 1'b1};
    scen[4] = '{"after_missing", 16, 15, 1'b0, 1'b1, 1'b0};

    tick(); tick();
    rst = 1'b1;
    tick();
    chk("reset_ready", {127'd0, pix_ready}, 128'd1);
    chk("reset_image", image_out, '0);
    chk("reset_cnt", {120'd0, frame_cnt}, 128'd0);

    // Basic back-to-back frame, then start/image_ready timing against filt_done.
    for (int i = 0; i < N; i++) beat(8'h10 + 8'(i), i == N - 1);
    chk("basic_start_T1", {127'd0, start}, 128'd1);
    chk("basic_irdy_T1", {127'd0, image_ready}, 128'd1);
    chk("basic_image", image_out, 128'h1F1E1D1C1B1A19181716151413121110);
    tick();
    chk("basic_start_T2", {127'd0, start}, 128'd0);
    chk("basic_irdy_wait", {127'd0, image_ready}, 128'd1);
    exp_frames++;
    chk("basic_cnt", {120'd0, frame_cnt}, 128'(exp_frames));

    // Backpressure: a queued beat is held through WAIT and taken the cycle after filt_done.
    held = image_out;
    pix_in = 8'h55; pix_last = 1'b0; pix_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("bp_ready_low", {127'd0, pix_ready}, 128'd0);
      chk("bp_image_frozen", image_out, held);
    end
    filt_done = 1'b1;
    tick();
    filt_done = 1'b0;
    chk("done_irdy_low", {127'd0, image_ready}, 128'd0);
    chk("done_ready_high", {127'd0, pix_ready}, 128'd1);
    tick();
    chk("bp_first_beat", {120'd0, image_out[7:0]}, 128'h55);
    pix_valid = 1'b0;
    for (int i = 1; i < N; i++) beat(8'h60 + 8'(i), i == N - 1);
    exp_img = 128'h6F6E6D6C6B6A69686766656463626155;
    chk("bp_frame2_image", image_out, exp_img);
    release_filter(4);
    exp_frames++;

    // Scenario table: framing errors, gapped input, recovery frames.
    foreach (scen[s]) begin
      base = 8'h20 + 8'(s * 16);
      for (int i = 0; i < scen[s].n; i++) begin
        beat(base + 8'(i), i == scen[s].last_at);
        if (scen[s].gap && i != scen[s].n - 1) tick();
      end
      chk({scen[s].name, "_start"}, {127'd0, start}, {127'd0, scen[s].exp_start});
      chk({scen[s].name, "_err"}, {127'd0, frame_err}, {127'd0, scen[s].exp_err});
      tick();
      chk({scen[s].name, "_err_1cyc"}, {127'd0, frame_err}, 128'd0);
      if (scen[s].exp_start) begin
        exp_frames++;
        exp_img = '0;
        for (int i = 0; i < N; i++) exp_img[i*DW +: DW] = base + 8'(i);
        chk({scen[s].name, "_image"}, image_out, exp_img);
        release_filter(4);
      end
      chk({scen[s].name, "_cnt"}, {120'd0, frame_cnt}, 128'(exp_frames));
    end

    // Reset during beat 8 of a frame.
    for (int i = 0; i < 7; i++) beat(8'hA0 + 8'(i), 1'b0);
    pix_in = 8'hA7; pix_valid = 1'b1; rst = 1'b0;
    tick();
    rst = 1'b1; pix_valid = 1'b0;
    exp_frames = 0;
    chk("rst_mid_image", image_out, '0);
    chk("rst_mid_cnt", {120'd0, frame_cnt}, 128'd0);
    chk("rst_mid_ready", {127'd0, pix_ready}, 128'd1);
    for (int i = 0; i < N; i++) beat(8'hB0 + 8'(i), i == N - 1);
    exp_frames++;
    chk("rst_mid_repack", image_out, 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0);

    // Reset during WAIT.
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_frames = 0;
    chk("rst_wait_irdy", {127'd0, image_ready}, 128'd0);
    chk("rst_wait_image", image_out, '0);
    chk("rst_wait_cnt", {120'd0, frame_cnt}, 128'd0);
    for (int i = 0; i < N; i++) beat(8'hC0 + 8'(i), i == N - 1);
    chk("rst_wait_repack", image_out, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);
    release_filter(2);

    // Randomized traffic; inputs are held while a beat is stalled.
    for (int c = 0; c < 4000; c++) begin
      if (!(pix_valid && !pix_ready)) begin
        pix_valid = ($urandom_range(0, 3) != 0);
        pix_in    = 8'($urandom);
        pix_last  = (m_len == N - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 24) == 0);
      end
      filt_done = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst = 1'b1; pix_valid = 1'b0; pix_last = 1'b0; filt_done = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

endmodule

// File: doc/gauss_frame_loader.md
Name: gauss_frame_loader

Overview:
- Upstream feeder for the Gaussian filter stage.
- Accepts a serial pixel stream (row-major, one pixel per accepted beat) over a valid/ready handshake.
- Packs the pixels into the flattened frame bus, then presents the frame to the filter with image_ready held and a one-cycle start pulse.
- Holds the frame stable until the filter reports done, then re-arms for the next frame.

Parameters:
- rows, 4, image height in pixels
- cols, 4, image width in pixels
- data_width, 8, bits per pixel

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- pix_in  in  data_width  incoming pixel value
- pix_valid  in  1  pix_in/pix_last valid this cycle
- pix_last  in  1  marks final pixel of a frame; qualified by pix_valid
- pix_ready  out  1  loader can accept a pixel this cycle
- image_out  out  data_width*rows*cols  packed frame; pixel i at bits [i*data_width +: data_width]
- image_ready  out  1  frame on image_out is complete and stable
- start  out  1  one-cycle launch pulse to filter
- filt_done  in  1  filter's done signal
- frame_err  out  1  one-cycle pulse on framing error
- frame_cnt  out  8  count of frames launched, wraps 255->0

Behaviour:
- N = rows*cols.
- Pixel index counter: width clog2(N). Beat accepted when pix_valid && pix_ready.
- Reset (rst==0 at clock edge), from any state including mid-frame or mid-WAIT:
  - state=FILL, index=0, image_out=0, image_ready=0, start=0, frame_err=0, frame_cnt=0.
  - pix_ready=1 from the first cycle after reset release.
- States:
  - FILL: pix_ready=1. On accepted beat, image_out[index] <= pix_in.
    - index<N-1 and pix_last=0: index++.
    - index<N-1 and pix_last=1: frame_err pulses next cycle; index<=0; partial frame discarded (written bytes remain but are not launched); stay FILL.
    - index==N-1 and pix_last=0: frame_err pulse; index<=0; stay FILL.
    - index==N-1 and pix_last=1: index<=0; -> LAUNCH.
  - LAUNCH (exactly one cycle): start=1, image_ready=1, pix_ready=0, frame_cnt++. filt_done ignored. -> WAIT.
  - WAIT: start=0, image_ready=1, pix_ready=0. image_out frozen. On filt_done==1: image_ready<=0, -> FILL.
- Latency:
  - Final beat accepted at edge T: start and image_ready are high in cycle T..T+1.
  - filt_done sampled at edge D: image_ready low and pix_ready high from D onward; a new pixel can be accepted at edge D+1.
- pix_ready is registered from state, never combinationally from pix_valid.
- Upstream must hold pix_in/pix_last while pix_valid && !pix_ready.
- pix_last with pix_valid=0 is ignored.
- filt_done in FILL is ignored.
- frame_err is never asserted together with start.
- N==1: every beat must carry pix_last; otherwise frame_err.

Test Plan:
- Basic frame (rows=cols=4):
  - Stimulus: 16 back-to-back beats 0x10..0x1F, pix_last on 0x1F; filt_done pulsed 5 cycles after start.
  - Response: image_out = 0x1F1E1D1C1B1A19181716151413121110; start high exactly 1 cycle, in the cycle after the last beat; image_ready high from start until the edge sampling filt_done; frame_cnt=1.
- Backpressure:
  - Stimulus: pix_valid held high with a second frame queued during WAIT.
  - Response: pix_ready=0 throughout LAUNCH/WAIT, no beats consumed, image_out unchanged; first beat of frame 2 accepted the cycle after filt_done.
- Early pix_last:
  - Stimulus: pix_last on beat 5 of 16.
  - Response: frame_err 1-cycle pulse, no start, frame_cnt unchanged; a following correct 16-beat frame launches normally.
- Missing pix_last:
  - Stimulus: 16 beats with no pix_last.
  - Response: frame_err pulse after beat 16, no start; next frame starts at index 0.
- Gapped input:
  - Stimulus: pix_valid toggled 1/0 every cycle over 16 beats.
  - Response: same image_out as the back-to-back case; start one cycle after the 16th accepted beat.
- Reset mid-operation:
  - Stimulus: rst=0 for 1 cycle during beat 8, and separately during WAIT.
  - Response: image_out=0, image_ready=0, frame_cnt=0, state FILL; a subsequent full frame packs from index 0.
